// File: rtl/furv_mem_pkg.sv
// Shared types and constants for the instruction/data RAM arbiter.
package furv_mem_pkg;

    localparam int DEFAULT_ADDR_W = 6;
    localparam int DEFAULT_DATA_W = 32;

    localparam int PORT_I = 0;
    localparam int PORT_D = 1;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        RWAIT,
        WR
    } arb_state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundles the core-side req/ack ports and the RAM-side command ports of the arbiter.
interface ram_arbiter_if
    import furv_mem_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) ();

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ack;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;

    logic [ADDR_W-1:0] ram_read_addr;
    logic [ADDR_W-1:0] ram_write_addr;
    logic [DATA_W-1:0] ram_data_in;
    logic              ram_mem_read;
    logic              ram_mem_write;
    logic [DATA_W-1:0] ram_data_out;
    logic              ram_read_ack;

    // The arbiter sits on the slave side; core ports and the RAM model drive the master side.
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_data_out, ram_read_ack,
        output i_rdata, i_ack, d_rdata, d_ack,
        output ram_read_addr, ram_write_addr, ram_data_in, ram_mem_read, ram_mem_write
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_data_out, ram_read_ack,
        input  i_rdata, i_ack, d_rdata, d_ack,
        input  ram_read_addr, ram_write_addr, ram_data_in, ram_mem_read, ram_mem_write
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant logic; the last-grant flop only moves when both ports compete.
module rr_arb2
    import furv_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] eligible,
    input  logic       update,
    output logic [1:0] gnt
);

    logic lastGrantD_q;

    always_comb begin
        gnt = 2'b00;
        case (eligible)
            2'b01:   gnt[PORT_I] = 1'b1;
            2'b10:   gnt[PORT_D] = 1'b1;
            2'b11: begin
                if (lastGrantD_q) gnt[PORT_I] = 1'b1;
                else              gnt[PORT_D] = 1'b1;
            end
            default: gnt = 2'b00;
        endcase
    end

    // Starting at D means the first contested grant after reset goes to I.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lastGrantD_q <= 1'b1;
        end else if (update && (&eligible)) begin
            lastGrantD_q <= gnt[PORT_D];
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one 64x32 RAM between the fetch port and the load/store port, one transaction at a time.
// The RAM's read_clk and write_clk are tied to clk at the integration level.
module ram_arbiter
    import furv_mem_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic          clk,
    input  logic          rst,
    ram_arbiter_if.slave  bus
);

    arb_state_t        state_q,     state_d;
    logic              grantD_q,    grantD_d;
    logic              iAck_q,      iAck_d;
    logic              dAck_q,      dAck_d;
    logic [DATA_W-1:0] iRdata_q,    iRdata_d;
    logic [DATA_W-1:0] dRdata_q,    dRdata_d;
    logic [ADDR_W-1:0] readAddr_q,  readAddr_d;
    logic [ADDR_W-1:0] writeAddr_q, writeAddr_d;
    logic [DATA_W-1:0] dataIn_q,    dataIn_d;
    logic              memRead_q,   memRead_d;
    logic              memWrite_q,  memWrite_d;

    logic [1:0] eligible;
    logic [1:0] gnt;
    logic       arbUpdate;

    // A port whose ack is showing this cycle is masked so its held req is not issued twice.
    assign eligible[PORT_I] = bus.i_req & ~iAck_q;
    assign eligible[PORT_D] = bus.d_req & ~dAck_q;
    assign arbUpdate        = (state_q == IDLE);

    rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .rst      (rst),
        .eligible (eligible),
        .update   (arbUpdate),
        .gnt      (gnt)
    );

    always_comb begin
        state_d     = state_q;
        grantD_d    = grantD_q;
        iAck_d      = 1'b0;
        dAck_d      = 1'b0;
        iRdata_d    = iRdata_q;
        dRdata_d    = dRdata_q;
        readAddr_d  = readAddr_q;
        writeAddr_d = writeAddr_q;
        dataIn_d    = dataIn_q;
        memRead_d   = 1'b0;
        memWrite_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt[PORT_I]) begin
                    grantD_d   = 1'b0;
                    readAddr_d = bus.i_addr;
                    memRead_d  = 1'b1;
                    state_d    = RD;
                end else if (gnt[PORT_D]) begin
                    grantD_d = 1'b1;
                    if (bus.d_we) begin
                        writeAddr_d = bus.d_addr;
                        dataIn_d    = bus.d_wdata;
                        memWrite_d  = 1'b1;
                        state_d     = WR;
                    end else begin
                        readAddr_d = bus.d_addr;
                        memRead_d  = 1'b1;
                        state_d    = RD;
                    end
                end
            end
            RD: begin
                state_d = RWAIT;
            end
            RWAIT: begin
                if (bus.ram_read_ack) begin
                    if (grantD_q) begin
                        dRdata_d = bus.ram_data_out;
                        dAck_d   = 1'b1;
                    end else begin
                        iRdata_d = bus.ram_data_out;
                        iAck_d   = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            WR: begin
                dAck_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grantD_q    <= 1'b0;
            iAck_q      <= 1'b0;
            dAck_q      <= 1'b0;
            iRdata_q    <= '0;
            dRdata_q    <= '0;
            readAddr_q  <= '0;
            writeAddr_q <= '0;
            dataIn_q    <= '0;
            memRead_q   <= 1'b0;
            memWrite_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            grantD_q    <= grantD_d;
            iAck_q      <= iAck_d;
            dAck_q      <= dAck_d;
            iRdata_q    <= iRdata_d;
            dRdata_q    <= dRdata_d;
            readAddr_q  <= readAddr_d;
            writeAddr_q <= writeAddr_d;
            dataIn_q    <= dataIn_d;
            memRead_q   <= memRead_d;
            memWrite_q  <= memWrite_d;
        end
    end

    assign bus.i_ack          = iAck_q;
    assign bus.i_rdata        = iRdata_q;
    assign bus.d_ack          = dAck_q;
    assign bus.d_rdata        = dRdata_q;
    assign bus.ram_read_addr  = readAddr_q;
    assign bus.ram_write_addr = writeAddr_q;
    assign bus.ram_data_in    = dataIn_q;
    assign bus.ram_mem_read   = memRead_q;
    assign bus.ram_mem_write  = memWrite_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: behavioural RAM, shadow memory and a transaction-level
// model of grant order and latency.
module tb_ram_arbiter;
    import furv_mem_pkg::*;

    localparam int AW    = 6;
    localparam int DW    = 32;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks;
    int          failures;
    int          cycleCount;
    logic        ramPreload;
    logic [1:0]  ackDelay;
    logic [3:0]  ackShift;
    logic [DW-1:0] ramMem [DEPTH];
    logic [DW-1:0] shadow [DEPTH];
    bit          lastGrantD;
    logic [DW-1:0] lastIData;
    logic [DW-1:0] lastDData;

    // Behavioural RAM: read_ack is a registered copy of mem_read, optionally delayed further.
    always @(posedge clk) begin
        cycleCount <= cycleCount + 1;
        if (ramPreload) begin
            ackShift <= '0;
            for (int i = 0; i < DEPTH; i++) ramMem[i] <= 32'hC0DE_0000 + i;
        end else begin
            ackShift <= {ackShift[2:0], bus.ram_mem_read};
            if (bus.ram_mem_read)  bus.ram_data_out <= ramMem[bus.ram_read_addr];
            if (bus.ram_mem_write) ramMem[bus.ram_write_addr] <= bus.ram_data_in;
        end
    end
    assign bus.ram_read_ack = ackShift[ackDelay];

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        ramPreload = 1'b0;
        checks++;
        if ({bus.i_ack, bus.d_ack, bus.i_rdata, bus.d_rdata, bus.ram_read_addr, bus.ram_write_addr,
             bus.ram_data_in, bus.ram_mem_read, bus.ram_mem_write} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got i_ack=%b d_ack=%b i_rdata=%h d_rdata=%h rd=%b wr=%b expected all 0",
                     bus.i_ack, bus.d_ack, bus.i_rdata, bus.d_rdata, bus.ram_mem_read, bus.ram_mem_write);
        end
        @(negedge clk);
        rst = 1'b0;
        lastGrantD = 1'b1;
        lastIData  = '0;
        lastDData  = '0;
    endtask

    task automatic test_write_single;
        int start, rel, wrPulses, wrCycle, dAcks, dAckCycle, iAcks;
        logic [AW-1:0] wrAddr;
        logic [DW-1:0] wrData;
        bit dropD;
        wrPulses = 0; wrCycle = -1; dAcks = 0; dAckCycle = -1; iAcks = 0;
        wrAddr = '0; wrData = '0;
        @(posedge clk); #1;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 6'd5; bus.d_wdata = 32'hDEAD_BEEF;
        start = cycleCount;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            rel = cycleCount - start;
            dropD = 1'b0;
            if (bus.ram_mem_write) begin
                wrPulses++; wrCycle = rel; wrAddr = bus.ram_write_addr; wrData = bus.ram_data_in;
            end
            if (bus.i_ack) iAcks++;
            if (bus.d_ack) begin dAcks++; dAckCycle = rel; dropD = 1'b1; end
            if (dropD) begin @(posedge clk); #1; bus.d_req = 1'b0; bus.d_we = 1'b0; end
        end
        shadow[5] = 32'hDEAD_BEEF;
        checks++;
        if (wrPulses !== 1 || wrCycle !== 1) begin
            failures++;
            $display("[TB] FAIL write_pulse: got pulses=%0d cycle=%0d expected pulses=1 cycle=1", wrPulses, wrCycle);
        end
        checks++;
        if (wrAddr !== 6'd5 || wrData !== 32'hDEAD_BEEF) begin
            failures++;
            $display("[TB] FAIL write_bus: got addr=%0d data=%h expected addr=5 data=deadbeef", wrAddr, wrData);
        end
        checks++;
        if (dAcks !== 1 || dAckCycle !== 2) begin
            failures++;
            $display("[TB] FAIL write_ack: got acks=%0d cycle=%0d expected acks=1 cycle=2", dAcks, dAckCycle);
        end
        checks++;
        if (ramMem[5] !== 32'hDEAD_BEEF) begin
            failures++;
            $display("[TB] FAIL write_cell: got %h expected deadbeef", ramMem[5]);
        end
        checks++;
        if (iAcks !== 0) begin
            failures++;
            $display("[TB] FAIL write_no_iack: got %0d expected 0", iAcks);
        end
    endtask

    task automatic test_read_after_write;
        int start, rel, rdPulses, rdCycle, iAcks, iAckCycle, dAcks;
        logic [AW-1:0] rdAddr;
        logic [DW-1:0] gotData;
        bit dropI;
        rdPulses = 0; rdCycle = -1; iAcks = 0; iAckCycle = -1; dAcks = 0;
        rdAddr = '0; gotData = '0;
        @(posedge clk); #1;
        bus.i_req = 1'b1; bus.i_addr = 6'd5;
        start = cycleCount;
        for (int n = 0; n < 9; n++) begin
            @(negedge clk);
            rel = cycleCount - start;
            dropI = 1'b0;
            if (bus.ram_mem_read) begin rdPulses++; rdCycle = rel; rdAddr = bus.ram_read_addr; end
            if (bus.d_ack) dAcks++;
            if (bus.i_ack) begin iAcks++; iAckCycle = rel; gotData = bus.i_rdata; dropI = 1'b1; end
            if (dropI) begin @(posedge clk); #1; bus.i_req = 1'b0; end
        end
        lastIData = shadow[5];
        checks++;
        if (rdPulses !== 1 || rdCycle !== 1 || rdAddr !== 6'd5) begin
            failures++;
            $display("[TB] FAIL fetch_read_pulse: got pulses=%0d cycle=%0d addr=%0d expected 1/1/5", rdPulses, rdCycle, rdAddr);
        end
        checks++;
        if (iAcks !== 1 || iAckCycle !== 3 || gotData !== shadow[5]) begin
            failures++;
            $display("[TB] FAIL fetch_ack: got acks=%0d cycle=%0d data=%h expected 1/3/%h", iAcks, iAckCycle, gotData, shadow[5]);
        end
        checks++;
        if (dAcks !== 0) begin
            failures++;
            $display("[TB] FAIL fetch_no_dack: got %0d expected 0", dAcks);
        end
    endtask

    task automatic test_both_alternate;
        int start, rel, idx, gotPort;
        int expPort [5];
        int expCyc  [5];
        logic [AW-1:0] iA;
        logic [DW-1:0] gotData, expData;
        bit dropI, dropD;
        iA = AW'($urandom_range(0, DEPTH - 1));
        expPort[0] = lastGrantD ? PORT_I : PORT_D;
        lastGrantD = (expPort[0] == PORT_D);
        for (int k = 0; k < 5; k++) begin
            expPort[k] = ((k % 2) == 0) ? expPort[0] : (expPort[0] == PORT_I ? PORT_D : PORT_I);
            expCyc[k]  = 3 * (k + 1);
        end
        @(posedge clk); #1;
        bus.i_req = 1'b1; bus.i_addr = iA;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 6'd7;
        start = cycleCount;
        idx = 0;
        rel = 0;
        while (idx < 5 && rel < 25) begin
            @(negedge clk);
            rel = cycleCount - start;
            dropI = 1'b0; dropD = 1'b0;
            if (bus.i_ack || bus.d_ack) begin
                gotPort = bus.d_ack ? PORT_D : PORT_I;
                gotData = bus.d_ack ? bus.d_rdata : bus.i_rdata;
                expData = (expPort[idx] == PORT_D) ? shadow[7] : shadow[iA];
                checks++;
                if (gotPort !== expPort[idx] || rel !== expCyc[idx] || gotData !== expData) begin
                    failures++;
                    $display("[TB] FAIL alternate_ack%0d: got port=%0d cycle=%0d data=%h expected port=%0d cycle=%0d data=%h",
                             idx, gotPort, rel, gotData, expPort[idx], expCyc[idx], expData);
                end
                if (idx >= 3) begin
                    if (gotPort == PORT_D) dropD = 1'b1;
                    else                   dropI = 1'b1;
                end
                idx++;
            end
            if (dropI || dropD) begin
                @(posedge clk); #1;
                if (dropI) bus.i_req = 1'b0;
                if (dropD) bus.d_req = 1'b0;
            end
        end
        checks++;
        if (idx !== 5) begin
            failures++;
            $display("[TB] FAIL alternate_count: got %0d acks expected 5", idx);
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        lastIData = shadow[iA];
        lastDData = shadow[7];
        repeat (2) @(posedge clk);
    endtask

    task automatic test_fetch_stream;
        int start, rel, pulses, acks;
        bit stepI;
        pulses = 0; acks = 0;
        @(posedge clk); #1;
        bus.i_req = 1'b1; bus.i_addr = 6'd0;
        start = cycleCount;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            rel = cycleCount - start;
            stepI = 1'b0;
            if (bus.ram_mem_read) begin
                checks++;
                if (rel !== 1 + 4 * pulses || bus.ram_read_addr !== AW'(pulses)) begin
                    failures++;
                    $display("[TB] FAIL stream_issue%0d: got cycle=%0d addr=%0d expected cycle=%0d addr=%0d",
                             pulses, rel, bus.ram_read_addr, 1 + 4 * pulses, pulses);
                end
                pulses++;
            end
            if (bus.i_ack) begin
                checks++;
                if (rel !== 3 + 4 * acks || bus.i_rdata !== shadow[acks % DEPTH]) begin
                    failures++;
                    $display("[TB] FAIL stream_ack%0d: got cycle=%0d data=%h expected cycle=%0d data=%h",
                             acks, rel, bus.i_rdata, 3 + 4 * acks, shadow[acks % DEPTH]);
                end
                lastIData = shadow[acks % DEPTH];
                acks++;
                stepI = 1'b1;
            end
            if (stepI) begin
                @(posedge clk); #1;
                if (acks >= 3) bus.i_req = 1'b0;
                else           bus.i_addr = AW'(acks);
            end
        end
        checks++;
        if (pulses !== 3 || acks !== 3) begin
            failures++;
            $display("[TB] FAIL stream_count: got reads=%0d acks=%0d expected 3/3", pulses, acks);
        end
    endtask

    task automatic test_reset_midop;
        int start, rel, acks, rdPulses, got;
        logic [AW-1:0] a;
        a = AW'($urandom_range(0, DEPTH - 1));
        ackDelay = 2'd3;
        @(posedge clk); #1;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = a;
        start = cycleCount;
        rel = 0;
        while (rel < 2) begin @(negedge clk); rel = cycleCount - start; end
        rst = 1'b1;
        bus.d_req = 1'b0;
        #1;
        checks++;
        if ({bus.i_ack, bus.d_ack, bus.i_rdata, bus.d_rdata, bus.ram_read_addr, bus.ram_write_addr,
             bus.ram_data_in, bus.ram_mem_read, bus.ram_mem_write} !== '0) begin
            failures++;
            $display("[TB] FAIL midop_reset_outputs: got d_ack=%b d_rdata=%h read_addr=%0d rd=%b expected all 0",
                     bus.d_ack, bus.d_rdata, bus.ram_read_addr, bus.ram_mem_read);
        end
        @(negedge clk);
        rst = 1'b0;
        lastGrantD = 1'b1; lastIData = '0; lastDData = '0;
        acks = 0; rdPulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.i_ack || bus.d_ack) acks++;
            if (bus.ram_mem_read) rdPulses++;
        end
        checks++;
        if (acks !== 0 || rdPulses !== 0 || bus.d_rdata !== '0) begin
            failures++;
            $display("[TB] FAIL stray_read_ack: got acks=%0d reads=%0d d_rdata=%h expected 0/0/0", acks, rdPulses, bus.d_rdata);
        end
        ackDelay = 2'd0;
        a = AW'($urandom_range(0, DEPTH - 1));
        got = 0;
        @(posedge clk); #1;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = a;
        start = cycleCount;
        rel = 0;
        while (got == 0 && rel < 12) begin
            @(negedge clk);
            rel = cycleCount - start;
            if (bus.d_ack) begin
                got = 1;
                checks++;
                if (rel !== 3 || bus.d_rdata !== shadow[a]) begin
                    failures++;
                    $display("[TB] FAIL post_reset_read: got cycle=%0d data=%h expected cycle=3 data=%h", rel, bus.d_rdata, shadow[a]);
                end
                @(posedge clk); #1;
                bus.d_req = 1'b0;
            end
        end
        checks++;
        if (got !== 1) begin
            failures++;
            $display("[TB] FAIL post_reset_timeout: got acks=%0d expected 1", got);
        end
        bus.d_req = 1'b0;
        lastDData = shadow[a];
    endtask

    task automatic test_random_traffic;
        int mode, start, rel, latI, latD, expCycI, expCycD, gotI, gotD;
        int rdPulses, wrPulses, overlap, expRd, expWr;
        logic [AW-1:0] iA, dA;
        logic [DW-1:0] wd, expI, expD;
        bit dWe, useI, useD, iFirst, dBeforeI, dropI, dropD;
        for (int it = 0; it < 40; it++) begin
            mode = $urandom_range(0, 2);
            iA   = AW'($urandom_range(0, DEPTH - 1));
            dA   = AW'($urandom_range(0, DEPTH - 1));
            dWe  = 1'($urandom_range(0, 1));
            wd   = $urandom;
            useI = (mode != 1);
            useD = (mode != 0);
            latI = 3;
            latD = dWe ? 2 : 3;
            iFirst = 1'b1;
            if (mode == 2) begin
                iFirst     = lastGrantD;
                lastGrantD = !iFirst;
            end
            expCycI = (useD && !iFirst) ? latD + latI : latI;
            expCycD = (useI && iFirst)  ? latI + latD : latD;
            dBeforeI = useD && (!useI || !iFirst);
            expI = '0; expD = '0;
            if (useI && !dBeforeI) expI = shadow[iA];
            if (useD) begin
                if (dWe) shadow[dA] = wd;
                else     expD = shadow[dA];
            end
            if (useI && dBeforeI) expI = shadow[iA];
            expRd = int'(useI) + int'(useD && !dWe);
            expWr = int'(useD && dWe);

            @(posedge clk); #1;
            bus.i_req = useI; bus.i_addr = iA;
            bus.d_req = useD; bus.d_we = dWe; bus.d_addr = dA; bus.d_wdata = wd;
            start = cycleCount;
            rel = 0; gotI = 0; gotD = 0; rdPulses = 0; wrPulses = 0; overlap = 0;
            while (((useI && gotI == 0) || (useD && gotD == 0)) && rel < 15) begin
                @(negedge clk);
                rel = cycleCount - start;
                dropI = 1'b0; dropD = 1'b0;
                if (bus.ram_mem_read)  rdPulses++;
                if (bus.ram_mem_write) wrPulses++;
                if (bus.ram_mem_read && bus.ram_mem_write) overlap++;
                if (bus.i_ack) begin
                    gotI++;
                    checks++;
                    if (!useI || rel !== expCycI || bus.i_rdata !== expI) begin
                        failures++;
                        $display("[TB] FAIL random%0d_iack: got cycle=%0d data=%h expected used=%0d cycle=%0d data=%h",
                                 it, rel, bus.i_rdata, useI, expCycI, expI);
                    end
                    dropI = 1'b1;
                end
                if (bus.d_ack) begin
                    gotD++;
                    checks++;
                    if (!useD || rel !== expCycD || (!dWe && bus.d_rdata !== expD)) begin
                        failures++;
                        $display("[TB] FAIL random%0d_dack: got cycle=%0d data=%h expected used=%0d we=%0d cycle=%0d data=%h",
                                 it, rel, bus.d_rdata, useD, dWe, expCycD, expD);
                    end
                    dropD = 1'b1;
                end
                if (dropI || dropD) begin
                    @(posedge clk); #1;
                    if (dropI) bus.i_req = 1'b0;
                    if (dropD) begin bus.d_req = 1'b0; bus.d_we = 1'b0; end
                end
            end
            bus.i_req = 1'b0; bus.d_req = 1'b0;
            if (useI) lastIData = expI;
            if (useD && !dWe) lastDData = expD;
            checks++;
            if (gotI !== int'(useI) || gotD !== int'(useD)) begin
                failures++;
                $display("[TB] FAIL random%0d_acks: got i=%0d d=%0d expected i=%0d d=%0d", it, gotI, gotD, useI, useD);
            end
            checks++;
            if (rdPulses !== expRd || wrPulses !== expWr || overlap !== 0) begin
                failures++;
                $display("[TB] FAIL random%0d_ram_cmds: got reads=%0d writes=%0d overlap=%0d expected %0d/%0d/0",
                         it, rdPulses, wrPulses, overlap, expRd, expWr);
            end
            @(negedge clk);
            checks++;
            if (bus.i_rdata !== lastIData || bus.d_rdata !== lastDData) begin
                failures++;
                $display("[TB] FAIL random%0d_held_data: got i=%h d=%h expected i=%h d=%h",
                         it, bus.i_rdata, bus.d_rdata, lastIData, lastDData);
            end
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1;
        ramPreload = 1'b1;
        ackDelay = 2'd0;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        lastGrantD = 1'b1;
        lastIData = '0; lastDData = '0;
        for (int i = 0; i < DEPTH; i++) shadow[i] = 32'hC0DE_0000 + i;

        test_reset();
        test_write_single();
        test_read_after_write();
        test_both_alternate();
        test_fetch_stream();
        test_reset_midop();
        test_random_traffic();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single 64x32 dual-clock RAM between the core's instruction-fetch port (port I) and load/store port (port D).
- Drives both RAM clocks from the one system clock.
- Arbitrates round-robin and keeps at most one RAM transaction in flight.
- Converts the RAM's read/read_ack protocol into a per-port req/ack handshake.

Parameters:
- ADDR_W, 6, word address width; the RAM depth is 2**ADDR_W.
- DATA_W, 32, data word width.

Ports:
- clk  in  1  system clock; also drives RAM read_clk and write_clk.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  1  instruction fetch request; read-only.
- i_addr  in  ADDR_W  fetch word address.
- i_rdata  out  DATA_W  fetch data; valid when i_ack=1, held until the next I read completes.
- i_ack  out  1  one-cycle completion pulse for port I.
- d_req  in  1  data request.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  DATA_W  write data.
- d_rdata  out  DATA_W  load data; valid when d_ack=1 after a read, held otherwise.
- d_ack  out  1  one-cycle completion pulse for port D.
- ram_read_addr  out  ADDR_W  to RAM read_addr.
- ram_write_addr  out  ADDR_W  to RAM write_addr.
- ram_data_in  out  DATA_W  to RAM data_in.
- ram_mem_read  out  1  to RAM mem_read.
- ram_mem_write  out  1  to RAM mem_write.
- ram_data_out  in  DATA_W  from RAM data_out.
- ram_read_ack  in  1  from RAM read_ack; registered copy of mem_read.

Behaviour:
- Reset state: all outputs 0, state=IDLE, last_grant=D.
  - Reset mid-operation aborts the transaction with no ack.
  - A ram_read_ack arriving after reset is ignored.
- Requester rules:
  - Hold req, we, addr and wdata stable until its ack pulse.
  - The requester may keep req high to request another transaction.
  - In the cycle a port's ack=1, that port is masked from arbitration, which prevents a double issue.
- FSM states: IDLE, RD, RWAIT, WR. All RAM-side outputs are registered.
- IDLE:
  - Form eligible_x = x_req & ~x_ack.
  - If none is eligible, stay in IDLE.
  - If one is eligible, grant it.
  - If both are eligible, grant the port that is not last_grant, then update last_grant.
  - Granted read (I always reads; D when d_we=0): at the edge, ram_read_addr<=addr, ram_mem_read<=1, go to RD.
  - Granted write: ram_write_addr<=d_addr, ram_data_in<=d_wdata, ram_mem_write<=1, go to WR.
- RD: ram_mem_read<=0; go to RWAIT.
- RWAIT:
  - Wait for ram_read_ack=1.
  - On it, x_rdata<=ram_data_out and x_ack<=1 for the granted port, then go to IDLE.
  - The state waits indefinitely if read_ack never arrives.
- WR: ram_mem_write<=0, d_ack<=1, go to IDLE. The write is committed at the edge that leaves WR.
- Ack is a single-cycle pulse, cleared on the following edge.
- Latency, measured from the edge that samples req:
  - Read: ack is high in the 3rd cycle (edges 0 grant, 1 RAM capture, 2 ack set).
  - Write: ack is high in the 2nd cycle.
- Throughput: back-to-back reads on one port take 4 cycles each because of the mask cycle. Alternating I/D reads take 3 cycles each.
- A D read following a D write to the same address returns the new data.
- ram_mem_read and ram_mem_write are never both 1.
- Addresses wrap naturally at ADDR_W bits; there is no range check.
- d_we is ignored while d_req=0.

Decomposition:
- Package furv_mem_pkg holds:
  - ADDR_W and DATA_W defaults.
  - The arb_state_t enum {IDLE, RD, RWAIT, WR}.
  - Port index constants PORT_I=0, PORT_D=1.
- One sub-module: rr_arb2. It is combinational grant logic plus the last_grant flop, with inputs eligible[1:0] and update, and outputs gnt[1:0].
- The FSM and datapath registers live in ram_arbiter.

Test Plan:
1. Reset, then a D write of 0xDEADBEEF to addr 5 -> ram_mem_write pulses 1 cycle with write_addr=5; d_ack is high the 2nd cycle after sampling; RAM cell 5 = 0xDEADBEEF.
2. After scenario 1, an I read of addr 5 -> ram_mem_read pulses once; i_ack is high the 3rd cycle with i_rdata=0xDEADBEEF; d_ack stays 0.
3. i_req and d_req (read of addr 7) both asserted in the same cycle after reset -> I is granted first, then D; the D ack follows I's ack by 3 cycles. Both stay high continuously -> grants alternate I, D, I, D.
4. i_req held high for 3 fetches at addr 0, 1, 2 (addr changes on each ack) -> exactly 3 ram_mem_read pulses, 4 cycles apart; no duplicate issue.
5. rst asserted during RWAIT of a D read -> outputs go to 0 immediately; no d_ack; the stray ram_read_ack is ignored; the next request completes normally.
